// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM states, bus widths,
// default SRAM base address and the byte-to-word address mapping.
package sram_ctrl_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BUS_W  = 64;

  localparam logic [31:0] DEFAULT_SRAM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Subtraction wraps in 32 bits; the shifted result is truncated to the SRAM word space.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] addr,
                                                  input logic [31:0] base);
    return ADDR_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_pair_buffer.sv
// One-entry read buffer holding the last 64-bit SRAM word pair, used only
// when SRAM_PAIR_BUF_EN is defined.
module sram_pair_buffer
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-2:0] lookup_tag,
  output logic              hit,
  output logic [BUS_W-1:0]  data,
  input  logic              fill,
  input  logic [ADDR_W-2:0] fill_tag,
  input  logic [BUS_W-1:0]  fill_data,
  input  logic              inval,
  input  logic [ADDR_W-2:0] inval_tag
);

  logic              valid;
  logic [ADDR_W-2:0] tag;

  // Fill and invalidate never coincide: fills happen at the end of a read access,
  // invalidates when a write is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (inval && (inval_tag == tag)) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (lookup_tag == tag);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage front end for the 64-bit external SRAM: multi-cycle load/store with
// pipeline hold via ready. Optional pair buffer enabled by SRAM_PAIR_BUF_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] SRAM_BASE   = DEFAULT_SRAM_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  inout  wire  [BUS_W-1:0]  SRAM_DQ
);

  state_t            state;
  state_t            next_state;
  logic [15:0]       count;
  logic              op_write;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] read_data_q;
  logic [ADDR_W-1:0] req_addr;
  logic              last_cycle;
  logic              write_active;
  logic              hit_now;
  logic              start;

  assign req_addr     = word_addr(address, SRAM_BASE);
  assign last_cycle   = (count == 16'(WAIT_CYCLES - 1));
  assign write_active = (state == ACCESS) && op_write;
  assign start        = (state == IDLE) && (wr_en || rd_en) && !hit_now;

`ifdef SRAM_PAIR_BUF_EN
  logic             buf_hit;
  logic [BUS_W-1:0] buf_data;

  sram_pair_buffer u_pair_buffer (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (req_addr[ADDR_W-1:1]),
    .hit        (buf_hit),
    .data       (buf_data),
    .fill       ((state == ACCESS) && last_cycle && !op_write),
    .fill_tag   (SRAM_ADDR[ADDR_W-1:1]),
    .fill_data  (SRAM_DQ),
    .inval      ((state == IDLE) && wr_en),
    .inval_tag  (req_addr[ADDR_W-1:1])
  );

  assign hit_now   = (state == IDLE) && rd_en && !wr_en && buf_hit;
  assign read_data = hit_now ? (req_addr[0] ? buf_data[63:32] : buf_data[31:0]) : read_data_q;
`else
  assign hit_now   = 1'b0;
  assign read_data = read_data_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      op_write    <= 1'b0;
      lat_data    <= '0;
      SRAM_ADDR   <= '0;
      read_data_q <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        op_write  <= wr_en;
        lat_data  <= write_data;
        SRAM_ADDR <= req_addr;
        count     <= '0;
      end else if (state == ACCESS) begin
        count <= count + 16'd1;
        if (last_cycle && !op_write) begin
          read_data_q <= SRAM_ADDR[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ACCESS;
          ready      = 1'b0;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (last_cycle) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign SRAM_WE_N = ~write_active;
  assign SRAM_DQ   = write_active ? {32'b0, lat_data} : {BUS_W{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural word-level memory
// model and a simple SRAM device model; pair-buffer checks follow SRAM_PAIR_BUF_EN.
module tb_sram_controller;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_PAIR_BUF_EN
  localparam int HIT_FREEZE = 0;
`else
  localparam int HIT_FREEZE = W + 1;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [16:0] sram_addr;
  logic        sram_we_n;
  wire  [63:0] sram_dq;

  sram_controller #(.WAIT_CYCLES(W), .SRAM_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_DQ    (sram_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device: 32-bit cells, reads return the even/odd pair on the 64-bit bus.
  logic [31:0] sram_mem [0:131071];
  logic        dev_drive_en;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq[31:0];
  assign sram_dq = (sram_we_n && dev_drive_en) ?
                   {sram_mem[{sram_addr[16:1], 1'b1}], sram_mem[{sram_addr[16:1], 1'b0}]} : 64'bz;

  // Behavioural model state.
  logic [31:0] exp_mem [int];
  logic        req_active, req_write, req_hit, mon_en;
  logic [16:0] req_waddr;
  logic [31:0] exp_rdata, last_rdata;
  int          req_cycle, freeze_cnt;
  logic        buf_valid;
  logic [15:0] buf_tag;
  int          errors, checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model_waddr(input logic [31:0] a);
    return 17'((a - BASE) >> 2);
  endfunction

  function automatic logic model_hit(input logic [16:0] wa);
`ifdef SRAM_PAIR_BUF_EN
    return buf_valid && (buf_tag == wa[16:1]);
`else
    return 1'b0 && (wa == 17'd0);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (req_active && !ready) freeze_cnt++;
      if (!req_active) begin
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      end else if (req_hit) begin
        check("hit_ready", {31'd0, ready}, 32'd1);
        check("hit_data", read_data, exp_rdata);
      end else if (req_cycle == 0) begin
        check("req_ready", {31'd0, ready}, 32'd0);
      end else if (req_cycle <= W) begin
        check("acc_ready", {31'd0, ready}, 32'd0);
        check("acc_addr", {15'd0, sram_addr}, {15'd0, req_waddr});
        check("acc_we_n", {31'd0, sram_we_n}, {31'd0, !req_write});
      end else begin
        check("done_ready", {31'd0, ready}, 32'd1);
        check("done_we_n", {31'd0, sram_we_n}, 32'd1);
        check("done_data", read_data, req_write ? last_rdata : exp_rdata);
      end
    end
  end

  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got);
    logic [16:0] wa;
    wa = model_waddr(a);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    req_write  = w;
    req_waddr  = wa;
    req_hit    = !w && model_hit(wa);
    freeze_cnt = 0;
    if (w) begin
      exp_mem[int'(wa)] = d;
      if (buf_tag == wa[16:1]) buf_valid = 1'b0;
    end else begin
      exp_rdata = exp_mem.exists(int'(wa)) ? exp_mem[int'(wa)] : 32'd0;
    end
    req_cycle  = 0;
    req_active = 1'b1;
    if (!req_hit) begin
      while (req_cycle < W + 1) begin
        @(posedge clk); #1;
        req_cycle++;
      end
    end
    @(negedge clk);
    got = read_data;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    req_active = 1'b0;
    if (!w && !req_hit) begin
      last_rdata = exp_rdata;
      buf_valid  = 1'b1;
      buf_tag    = wa[16:1];
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] got;

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    dev_drive_en = 1'b1; mon_en = 1'b0; req_active = 1'b0; req_hit = 1'b0;
    req_write = 1'b0; req_waddr = '0; req_cycle = 0; freeze_cnt = 0;
    exp_rdata = '0; last_rdata = '0; buf_valid = 1'b0; buf_tag = '0;
    for (int i = 0; i < 131072; i++) sram_mem[i] = 32'd0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_addr", {15'd0, sram_addr}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    mon_en = 1'b1;

    // Reset pulsed during the second ACCESS cycle of a store to 2048.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd2048; write_data = 32'hAAAA5555;
    req_write = 1'b1; req_waddr = model_waddr(32'd2048); req_hit = 1'b0;
    req_cycle = 0; req_active = 1'b1;
    repeat (2) begin @(posedge clk); #1; req_cycle++; end
    mon_en = 1'b0; wr_en = 1'b0; rst = 1'b1;
    #1 check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    #1 rst = 1'b0;
    req_active = 1'b0;
    buf_valid = 1'b0;
    last_rdata = 32'd0;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_addr", {15'd0, sram_addr}, 32'd0);
    check("midrst_rdata", read_data, 32'd0);
    mon_en = 1'b1;

    do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, got);
    check("st1024_freeze", freeze_cnt, 32'd6);
    check("st1024_addr", {15'd0, sram_addr}, 32'd0);
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, got);
    check("ld1024_data", got, 32'hDEADBEEF);
    check("ld1024_freeze", freeze_cnt, 32'd6);
    check("ld1024_addr", {15'd0, sram_addr}, 32'd0);

    do_req(1'b1, 1'b0, 32'd1024, 32'h11111111, got);
    do_req(1'b1, 1'b0, 32'd1028, 32'h22222222, got);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, got);
    check("ld1028_data", got, 32'h22222222);
    check("ld1028_addr", {15'd0, sram_addr}, 32'd1);

    do_req(1'b1, 1'b1, 32'd1032, 32'h33333333, got);
    check("both_addr", {15'd0, sram_addr}, 32'd2);
    check("both_rdata", read_data, 32'h22222222);
    do_req(1'b0, 1'b1, 32'd1032, 32'd0, got);
    check("ld1032_data", got, 32'h33333333);

    do_req(1'b1, 1'b0, 32'd0, 32'h44444444, got);
    check("wrap_addr", {15'd0, sram_addr}, 32'h1FF00);
    do_req(1'b0, 1'b1, 32'd0, 32'd0, got);
    check("wrap_data", got, 32'h44444444);

    do_req(1'b0, 1'b1, 32'd1024, 32'd0, got);
    check("pair_lo_data", got, 32'h11111111);
    check("pair_lo_freeze", freeze_cnt, 32'd6);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, got);
    check("pair_hi_data", got, 32'h22222222);
    check("pair_hi_freeze", freeze_cnt, HIT_FREEZE);
    do_req(1'b1, 1'b0, 32'd1028, 32'h55555555, got);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, got);
    check("inval_data", got, 32'h55555555);
    check("inval_freeze", freeze_cnt, 32'd6);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
